uart_tx_block: RTL and testbench

Serial transmitter: the transmit-side counterpart of the 9-bit receive shift register (8 data + stop).
- Accepts a parallel byte on a one-cycle start strobe.
- Emits an async-serial frame on one line: start bit (0), 8 data bits LSB first, stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between the packet/control logic and the pad; a receiver running the same CLKS_PER_BIT sees the frame back.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_block_pts_sr.sv | 30 +++
 rtl/uart_tx_block.sv | 133 +++++++++++++
 tb/tb_uart_tx_block.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
// The PARITY state is used only in builds that define UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_block_pts_sr.sv
// Parallel-to-serial shift register; the transmit-side mirror of stp_sr.
// Loading takes priority over shifting. Vacated bits fill with 1s.
module pts_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] sr;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sr <= '1;
    end else if (load_enable) begin
      sr <= parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB) sr <= {sr[NUM_BITS-2:0], 1'b1};
      else           sr <= {1'b1, sr[NUM_BITS-1:1]};
    end
  end

  assign serial_out = SHIFT_MSB ? sr[NUM_BITS-1] : sr[0];

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT clocks each.
// Defining UART_TX_PARITY_EN inserts an even-parity bit ahead of the stop bit.
module uart_tx_block
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic          cnt_max, load, shift, sr_out, line_next, done_next;

  assign cnt_max = (cnt == CNT_MAX);

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk) begin
    if (!n_rst)    parity_bit <= 1'b0;
    else if (load) parity_bit <= ^tx_data;
  end
`endif

  pts_sr #(
    .NUM_BITS (DATA_BITS),
    .SHIFT_MSB(1'b0)
  ) u_pts_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_enable (load),
    .shift_enable(shift),
    .parallel_in (tx_data),
    .serial_out  (sr_out)
  );

  // The line is registered, so each bit is chosen at the edge that starts it:
  // the shifter's LSB is sampled and shifted out on the same edge.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt_max ? '0 : cnt + 1'b1;
    bit_idx_next = bit_idx;
    load         = 1'b0;
    shift        = 1'b0;
    line_next    = serial_out;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next  = '0;
        line_next = IDLE_LEVEL;
        if (tx_start) begin
          state_next = START;
          load       = 1'b1;
          line_next  = START_LEVEL;
        end
      end
      START: begin
        if (cnt_max) begin
          state_next   = DATA;
          bit_idx_next = '0;
          shift        = 1'b1;
          line_next    = sr_out;
        end
      end
      DATA: begin
        if (cnt_max) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            line_next  = parity_bit;
`else
            state_next = STOP;
            line_next  = STOP_LEVEL;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift        = 1'b1;
            line_next    = sr_out;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_max) begin
          state_next = STOP;
          line_next  = STOP_LEVEL;
        end
      end
`endif
      STOP: begin
        if (cnt_max) begin
          state_next = IDLE;
          done_next  = 1'b1;
          line_next  = IDLE_LEVEL;
        end
      end
      default: begin
        state_next = IDLE;
        line_next  = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      serial_out <= IDLE_LEVEL;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_idx_next;
      serial_out <= line_next;
      tx_busy    <= (state_next != IDLE);
      tx_done    <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// Self-checking bench for uart_tx_block: vector table, corner sequences, random frames.
// Follows UART_TX_PARITY_EN when defined so both builds can be checked.
module tb_uart_tx_block;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       serial_out;
  logic       tx_busy;
  logic       tx_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_block #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .serial_out(serial_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       par;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line level c cycles into a frame, from the frame definition.
  function automatic logic exp_line(input logic [7:0] d, input logic par, input int c);
    int b;
    b = c / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return par;
`endif
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge of cycle 0 of the new frame.
  task automatic send(input logic [7:0] d);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic par,
                             input int glitch_at, input logic [7:0] glitch_d,
                             input logic restart, input logic [7:0] next_d,
                             output int tail_high);
    int bad_line, bad_busy, bad_done, first_bad;
    bad_line = 0; bad_busy = 0; bad_done = 0; first_bad = -1;
    tail_high = 0;
    for (int c = 0; c < FLEN; c++) begin
      if (c > 0) @(negedge clk);
      if (serial_out !== exp_line(d, par, c)) begin
        bad_line++;
        if (first_bad < 0) first_bad = c;
      end
      if (tx_busy !== 1'b1) bad_busy++;
      if (tx_done !== 1'b0) bad_done++;
      tail_high = (serial_out === 1'b1) ? tail_high + 1 : 0;
      if (c == 0) tx_data = ~d;
      if (c == glitch_at) begin
        tx_start = 1'b1;
        tx_data  = glitch_d;
      end else if (c == glitch_at + 1) begin
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
      end
    end
    if (first_bad >= 0) $display("  %s: first bad line sample at cycle %0d", name, first_bad);
    chk({name, " line"}, bad_line, 0);
    chk({name, " busy"}, bad_busy, 0);
    chk({name, " early_done"}, bad_done, 0);
    @(negedge clk);
    if (serial_out === 1'b1) tail_high++;
    chk({name, " done_pulse"}, {tx_done, tx_busy, serial_out}, 3'b101);
    if (restart) begin
      tx_start = 1'b1;
      tx_data  = next_d;
    end
    @(negedge clk);
    tx_start = 1'b0;
    if (!restart) chk({name, " done_width"}, tx_done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   tail, bad;
    logic [7:0] d;

    vecs[0] = '{"vec_a5", 8'hA5, 1'b0};
    vecs[1] = '{"vec_3c", 8'h3C, 1'b0};
    vecs[2] = '{"vec_00", 8'h00, 1'b0};
    vecs[3] = '{"vec_ff", 8'hFF, 1'b0};
    vecs[4] = '{"vec_07", 8'h07, 1'b1};
    vecs[5] = '{"vec_80", 8'h80, 1'b1};
    vecs[6] = '{"vec_01", 8'h01, 1'b1};
    vecs[7] = '{"vec_fe", 8'hFE, 1'b1};

    n_rst = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_state", {serial_out, tx_busy, tx_done}, 3'b100);

    // Reset and start together: reset wins.
    tx_start = 1'b1; tx_data = 8'h55;
    @(negedge clk);
    chk("reset_beats_start", {serial_out, tx_busy}, 2'b10);
    tx_start = 1'b0;
    n_rst = 1'b1;

    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({serial_out, tx_busy, tx_done} !== 3'b100) bad++;
    end
    chk("idle_50", bad, 0);

    foreach (vecs[i]) begin
      send(vecs[i].data);
      check_frame(vecs[i].name, vecs[i].data, vecs[i].par, -1, 8'h00, 1'b0, 8'h00, tail);
      repeat (3) @(negedge clk);
    end

    // Start request mid-frame is ignored and the captured byte is kept.
    send(8'h3C);
    check_frame("ignore_start", 8'h3C, 1'b0, 40, 8'hFF, 1'b0, 8'h00, tail);
    bad = 0;
    repeat (FLEN) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("ignore_start_no_second_frame", bad, 0);

    // Back-to-back: second start coincides with the first done pulse.
    send(8'h00);
    check_frame("b2b_first", 8'h00, 1'b0, -1, 8'h00, 1'b1, 8'hFF, tail);
    chk("b2b_gap", tail, CPB + 1);
    check_frame("b2b_second", 8'hFF, 1'b0, -1, 8'h00, 1'b0, 8'h00, tail);

    // Reset at cycle 55 aborts the frame with no done pulse.
    send(8'hA5);
    repeat (55) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    chk("abort_state", {serial_out, tx_busy, tx_done}, 3'b100);
    bad = 0;
    repeat (FLEN + 10) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_busy !== 1'b0 || serial_out !== 1'b1) bad++;
    end
    chk("abort_quiet", bad, 0);
    send(8'hA5);
    check_frame("after_abort", 8'hA5, 1'b0, -1, 8'h00, 1'b0, 8'h00, tail);

    for (int r = 0; r < 8; r++) begin
      int g;
      d = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FLEN - 2)) : -1;
      send(d);
      check_frame($sformatf("rand%0d_%02h", r, d), d, ^d, g, 8'($urandom), 1'b0, 8'h00, tail);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
